// File: rtl/tpu_pkg.sv
// Shared types and helpers for the N x N systolic matrix unit.
// Contents:
//   state_t    - sequencer states (LOAD, COMPUTE, OUTPUT)
//   acc_width  - accumulator width for an N-deep signed dot product
//   cnt_width  - width of the byte/cycle/result counters for a given N
//   sat_relu   - optional ReLU followed by saturation to a signed OW-bit range
package tpu_pkg;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        OUTPUT  = 2'd2
    } state_t;

    localparam int N_MAX     = 4;
    localparam int CNT_W_MAX = $clog2(2 * N_MAX * N_MAX);

    // The worst-case product magnitude needs 2*DW bits; summing N of them
    // adds clog2(N) bits, so the accumulator can never wrap.
    function automatic int acc_width(input int n, input int dw);
        return 2 * dw + $clog2(n);
    endfunction

    // The counters index the 2*N*N operand bytes, which is the largest
    // range any of them has to cover.
    function automatic int cnt_width(input int n);
        return $clog2(2 * n * n);
    endfunction

    function automatic longint sat_relu(input longint v, input logic relu_en, input int ow);
        longint hi;
        longint lo;
        longint r;
        hi = (longint'(1) <<< (ow - 1)) - 1;
        lo = -hi - 1;
        r  = (relu_en && v < 0) ? 0 : v;
        if (r > hi) r = hi;
        if (r < lo) r = lo;
        return r;
    endfunction

endpackage

// File: rtl/mac_pe.sv
// One processing element of the systolic grid.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   clr          - synchronous clear of accumulator and pass-through registers
//   en           - accumulate a_in*b_in and capture operands for forwarding
//   a_in, b_in   - signed operands from the left / top neighbour
//   a_out, b_out - registered operands towards the right / bottom neighbour
//   acc          - signed running sum
module mac_pe
    import tpu_pkg::*;
#(
    parameter int DW    = 8,
    parameter int ACC_W = 17
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [DW-1:0]    a_in,
    input  logic signed [DW-1:0]    b_in,
    output logic signed [DW-1:0]    a_out,
    output logic signed [DW-1:0]    b_out,
    output logic signed [ACC_W-1:0] acc
);

    localparam int PW = 2 * DW;

    logic signed [PW-1:0] prod;

    assign prod = PW'(a_in) * PW'(b_in);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            a_out <= '0;
            b_out <= '0;
        end else if (clr) begin
            acc   <= '0;
            a_out <= '0;
            b_out <= '0;
        end else if (en) begin
            acc   <= acc + {{(ACC_W-PW){prod[PW-1]}}, prod};
            a_out <= a_in;
            b_out <= b_in;
        end
    end

endmodule

// File: rtl/systolic_mmu_nxn.sv
// N x N signed systolic matrix unit with a byte-serial host interface.
// Loads W then A (row-major, 2*N*N bytes), computes C = A*W or A*W^T on an
// output-stationary PE grid, then streams N*N saturated result bytes.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   in_valid/in_data      - operand byte stream, accepted while in_ready
//   in_ready              - high while loading
//   transpose, relu       - pass options, captured with the final operand byte
//   out_valid/out_data    - result stream, row-major, held while out_ready=0
//   out_ready             - consumer accepts result
//   busy                  - high during compute and output
//   done                  - one-cycle pulse after the last result is accepted
//
// state   | meaning
// LOAD    | accepting operand bytes into the store
// COMPUTE | cycle 0 clears PEs, cycles 1..3N-2 stream skewed operands
// OUTPUT  | presenting results C[0][0]..C[N-1][N-1]
module systolic_mmu_nxn
    import tpu_pkg::*;
#(
    parameter int N  = 2,
    parameter int DW = 8,
    parameter int OW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    input  logic          transpose,
    input  logic          relu,
    output logic          out_valid,
    output logic [OW-1:0] out_data,
    input  logic          out_ready,
    output logic          busy,
    output logic          done
);

    localparam int ACC_W = acc_width(N, DW);
    localparam int NN    = N * N;
    localparam int CW    = cnt_width(N);

    state_t           state_q, state_d;
    logic [CW-1:0]    load_cnt, cc, out_idx;
    logic             trans_q, relu_q, done_q;
    logic             in_acc, out_acc, load_last, cc_last, out_last;
    logic             pe_clr, pe_en;
    logic             unused_edge;

    logic signed [DW-1:0]    w_mem  [NN];
    logic signed [DW-1:0]    a_mem  [NN];
    logic signed [DW-1:0]    a_left [N];
    logic signed [DW-1:0]    b_top  [N];
    logic signed [DW-1:0]    a_pass [N][N];
    logic signed [DW-1:0]    b_pass [N][N];
    logic signed [ACC_W-1:0] acc_arr[NN];
    logic signed [ACC_W-1:0] acc_sel;

    assign in_acc    = in_valid && in_ready;
    assign out_acc   = out_valid && out_ready;
    assign load_last = (load_cnt == CW'(2 * NN - 1));
    assign cc_last   = (cc == CW'(3 * N - 2));
    assign out_last  = (out_idx == CW'(NN - 1));
    assign pe_clr    = (state_q == COMPUTE) && (cc == '0);
    assign pe_en     = (state_q == COMPUTE) && (cc != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= LOAD;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (in_acc && load_last) state_d = COMPUTE;
            COMPUTE: if (cc_last)             state_d = OUTPUT;
            OUTPUT:  if (out_acc && out_last) state_d = LOAD;
            default:                          state_d = LOAD;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == LOAD);
        out_valid = (state_q == OUTPUT);
        busy      = (state_q == COMPUTE) || (state_q == OUTPUT);
        done      = done_q;
        out_data  = '0;
        if (state_q == OUTPUT) out_data = OW'(sat_relu(longint'(acc_sel), relu_q, OW));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_cnt <= '0;
            cc       <= '0;
            out_idx  <= '0;
            trans_q  <= 1'b0;
            relu_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            if (in_acc) load_cnt <= load_last ? '0 : load_cnt + CW'(1);
            if (state_q == COMPUTE) cc <= cc_last ? '0 : cc + CW'(1);
            else                    cc <= '0;
            if (out_acc) out_idx <= out_last ? '0 : out_idx + CW'(1);
            if (in_acc && load_last) begin
                trans_q <= transpose;
                relu_q  <= relu;
            end
            done_q <= out_acc && out_last;
        end
    end

    // Operand store: bytes 0..NN-1 go to W, NN..2NN-1 go to A.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NN; k++) begin
                w_mem[k] <= '0;
                a_mem[k] <= '0;
            end
        end else if (in_acc) begin
            for (int k = 0; k < NN; k++) begin
                if (load_cnt == CW'(k))      w_mem[k] <= in_data;
                if (load_cnt == CW'(NN + k)) a_mem[k] <= in_data;
            end
        end
    end

    // Skewed edge feed: element s of row/column i enters at compute cycle 1+i+s.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_left[i] = '0;
            b_top[i]  = '0;
            for (int s = 0; s < N; s++) begin
                if (cc == CW'(1 + i + s)) begin
                    a_left[i] = a_mem[i*N + s];
                    b_top[i]  = trans_q ? w_mem[i*N + s] : w_mem[s*N + i];
                end
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic signed [DW-1:0] a_in, b_in;
            if (j == 0) begin : g_al
                assign a_in = a_left[i];
            end else begin : g_ap
                assign a_in = a_pass[i][j-1];
            end
            if (i == 0) begin : g_bt
                assign b_in = b_top[j];
            end else begin : g_bp
                assign b_in = b_pass[i-1][j];
            end
            mac_pe #(.DW(DW), .ACC_W(ACC_W)) u_pe (
                .clk   (clk),
                .rst   (rst),
                .clr   (pe_clr),
                .en    (pe_en),
                .a_in  (a_in),
                .b_in  (b_in),
                .a_out (a_pass[i][j]),
                .b_out (b_pass[i][j]),
                .acc   (acc_arr[i*N + j])
            );
        end
    end

    // Operands leaving the right and bottom edges of the grid are dropped.
    always_comb begin
        unused_edge = 1'b0;
        for (int i = 0; i < N; i++) begin
            unused_edge = unused_edge ^ (^a_pass[i][N-1]) ^ (^b_pass[N-1][i]);
        end
    end

    always_comb begin
        acc_sel = '0;
        for (int k = 0; k < NN; k++) begin
            if (out_idx == CW'(k)) acc_sel = acc_arr[k];
        end
    end

endmodule
